// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, forwarding
// selects, the register-zero constant and the packed control-output bundle.
package hazard_pkg;

  localparam logic [1:0] ST_RUN      = 2'b00;
  localparam logic [1:0] ST_MEM_WAIT = 2'b01;
  localparam logic [1:0] ST_FLUSH    = 2'b10;

  localparam logic [1:0] FW_NONE  = 2'b00;
  localparam logic [1:0] FW_EXMEM = 2'b10;
  localparam logic [1:0] FW_MEMWB = 2'b01;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic pipe_hold;
  } hazard_ctl_t;

  localparam hazard_ctl_t CTL_RUN   = 5'b11000;
  localparam hazard_ctl_t CTL_HOLD  = 5'b00001;
  localparam hazard_ctl_t CTL_FLUSH = 5'b11110;
  localparam hazard_ctl_t CTL_LU    = 5'b00010;
  localparam hazard_ctl_t CTL_RESET = 5'b00110;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard controller: decode/EX/MEM status in,
// pipeline register enables out.
interface pipeline_hazard_ctrl_if;
  // mem_req high means a MEM access is in flight; it completes on the cycle
  // mem_ready is also high. mem_req high with mem_ready low is a wait cycle.
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       ex_mem_read;
  logic [4:0] ex_wr_reg;
  logic       ex_branch_taken;
  logic       mem_req;
  logic       mem_ready;
  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_bubble;
  logic       pipe_hold;

  modport master (
    output id_rs, id_rt, ex_mem_read, ex_wr_reg, ex_branch_taken, mem_req, mem_ready,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold
  );

  modport slave (
    input  id_rs, id_rt, ex_mem_read, ex_wr_reg, ex_branch_taken, mem_req, mem_ready,
    output pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_loaduse_det.sv
// Load-use detector: a load in EX whose destination is read by the
// instruction in ID. Register zero never creates a dependency.
module hazard_loaduse_det
  import hazard_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_wr_reg,
  output logic       hazard
);

  assign hazard = ex_mem_read && (ex_wr_reg != REG_ZERO) &&
                  ((ex_wr_reg == id_rs) || (ex_wr_reg == id_rt));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. Define HAZARD_PERF_CNT_EN
// to add the saturating stall_cnt/flush_cnt performance counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int TO_W         = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  pipeline_hazard_ctrl_if.slave  bus,
  output logic                   mem_timeout,
  output logic [1:0]             ctrl_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]            stall_cnt,
  output logic [31:0]            flush_cnt
`endif
);

  localparam int              FC_W    = $clog2(FLUSH_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  logic [1:0]      state, state_nx, resume_st;
  logic [TO_W-1:0] to_cnt, to_nx;
  logic [FC_W-1:0] fl_cnt, fl_nx;
  logic            stall, lu_hit, lu_evt, tmo_set;
  hazard_ctl_t     ctl;

  hazard_loaduse_det u_loaduse (
    .id_rs       (bus.id_rs),
    .id_rt       (bus.id_rt),
    .ex_mem_read (bus.ex_mem_read),
    .ex_wr_reg   (bus.ex_wr_reg),
    .hazard      (lu_hit)
  );

  assign stall = bus.mem_req & ~bus.mem_ready;
  // A flush interrupted by a memory stall resumes with its frozen count.
  assign resume_st = (fl_cnt != '0) ? ST_FLUSH : ST_RUN;

  always_comb begin
    ctl      = CTL_RUN;
    state_nx = state;
    to_nx    = to_cnt;
    fl_nx    = fl_cnt;
    tmo_set  = 1'b0;
    lu_evt   = 1'b0;
    case (state)
      ST_MEM_WAIT: begin
        if (!stall) begin
          state_nx = resume_st;
        end else if (to_cnt == TO_LAST) begin
          tmo_set  = 1'b1;
          state_nx = resume_st;
        end else begin
          ctl   = CTL_HOLD;
          to_nx = to_cnt + 1'b1;
        end
      end
      ST_FLUSH: begin
        if (stall) begin
          ctl      = CTL_HOLD;
          state_nx = ST_MEM_WAIT;
          to_nx    = '0;
        end else begin
          ctl = CTL_FLUSH;
          if (fl_cnt <= FC_W'(1)) begin
            fl_nx    = '0;
            state_nx = ST_RUN;
          end else begin
            fl_nx = fl_cnt - 1'b1;
          end
        end
      end
      default: begin
        state_nx = ST_RUN;
        if (stall) begin
          ctl      = CTL_HOLD;
          state_nx = ST_MEM_WAIT;
          to_nx    = '0;
        end else if (bus.ex_branch_taken) begin
          ctl = CTL_FLUSH;
          if (FLUSH_CYCLES > 1) begin
            state_nx = ST_FLUSH;
            fl_nx    = FC_W'(FLUSH_CYCLES - 1);
          end
        end else if (lu_hit) begin
          ctl    = CTL_LU;
          lu_evt = 1'b1;
        end
      end
    endcase
    // While reset is held the pipeline is kept empty and not advancing.
    if (!reset_n) ctl = CTL_RESET;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_RUN;
      to_cnt      <= '0;
      fl_cnt      <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state  <= state_nx;
      to_cnt <= to_nx;
      fl_cnt <= fl_nx;
      if (tmo_set) mem_timeout <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((ctl.pipe_hold || lu_evt) && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (ctl.ifid_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

  assign bus.pc_write    = ctl.pc_write;
  assign bus.ifid_write  = ctl.ifid_write;
  assign bus.ifid_flush  = ctl.ifid_flush;
  assign bus.idex_bubble = ctl.idex_bubble;
  assign bus.pipe_hold   = ctl.pipe_hold;
  assign ctrl_state      = state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (FLUSH_CYCLES=1/MEM_TIMEOUT=255
// and FLUSH_CYCLES=2/MEM_TIMEOUT=3) driven with the same stimulus.
module tb_pipeline_hazard_ctrl;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  pipeline_hazard_ctrl_if bus0 ();
  pipeline_hazard_ctrl_if bus1 ();
  logic       mem_timeout0, mem_timeout1;
  logic [1:0] st0, st1;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt0, flush_cnt0, stall_cnt1, flush_cnt1;
`endif

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(1), .MEM_TIMEOUT(255), .TO_W(8)) dut0 (
    .clock(clock), .reset_n(reset_n), .bus(bus0.slave),
    .mem_timeout(mem_timeout0), .ctrl_state(st0)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0)
`endif
  );

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(3), .TO_W(2)) dut1 (
    .clock(clock), .reset_n(reset_n), .bus(bus1.slave),
    .mem_timeout(mem_timeout1), .ctrl_state(st1)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
`endif
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [7:0] exp_q[$];
  // Vector layout: {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, mem_timeout, state[1:0]}
  logic [7:0] obs  [2];
  logic [7:0] expv [2];

  // ---------------- reference model ----------------
  // Tracks stall episodes by counting held cycles, and pending flush cycles.
  bit m_wait       [2];
  int m_hold_n     [2];
  int m_flush_left [2];
  bit m_tmo        [2];
  int p_fc [2] = '{1, 2};
  int p_to [2] = '{255, 3};

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_wait[k] = 0; m_hold_n[k] = 0; m_flush_left[k] = 0; m_tmo[k] = 0;
    end
  endfunction

  function automatic logic [7:0] model_eval(int k, logic [4:0] rs, logic [4:0] rt,
                                            logic [4:0] wr, logic mr, logic br,
                                            logic rq, logic rdy);
    logic       stall, lu, tmo_now;
    logic [1:0] st_now;
    logic [4:0] o;
    stall   = rq && !rdy;
    lu      = mr && (wr != 0) && ((wr == rs) || (wr == rt));
    st_now  = m_wait[k] ? 2'b01 : ((m_flush_left[k] > 0) ? 2'b10 : 2'b00);
    tmo_now = m_tmo[k];
    o = 5'b11000;
    if (m_wait[k]) begin
      if (!stall) m_wait[k] = 0;
      else if (m_hold_n[k] == p_to[k]) begin m_wait[k] = 0; m_tmo[k] = 1; end
      else begin o = 5'b00001; m_hold_n[k]++; end
    end else if (stall) begin
      o = 5'b00001; m_wait[k] = 1; m_hold_n[k] = 1;
    end else if (m_flush_left[k] > 0) begin
      o = 5'b11110; m_flush_left[k]--;
    end else if (br) begin
      o = 5'b11110; m_flush_left[k] = p_fc[k] - 1;
    end else if (lu) begin
      o = 5'b00010;
    end
    return {o, tmo_now, st_now};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wr,
                       input logic mr, input logic br, input logic rq, input logic rdy);
    bus0.id_rs = rs; bus0.id_rt = rt; bus0.ex_wr_reg = wr; bus0.ex_mem_read = mr;
    bus0.ex_branch_taken = br; bus0.mem_req = rq; bus0.mem_ready = rdy;
    bus1.id_rs = rs; bus1.id_rt = rt; bus1.ex_wr_reg = wr; bus1.ex_mem_read = mr;
    bus1.ex_branch_taken = br; bus1.mem_req = rq; bus1.mem_ready = rdy;
  endtask

  task automatic sample();
    obs[0] = {bus0.pc_write, bus0.ifid_write, bus0.ifid_flush, bus0.idex_bubble,
              bus0.pipe_hold, mem_timeout0, st0};
    obs[1] = {bus1.pc_write, bus1.ifid_write, bus1.ifid_flush, bus1.idex_bubble,
              bus1.pipe_hold, mem_timeout1, st1};
  endtask

  // One pipeline cycle: drive mid-cycle, sample before the next rising edge.
  task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wr,
                      input logic mr, input logic br, input logic rq, input logic rdy);
    @(negedge clock);
    drive(rs, rt, wr, mr, br, rq, rdy);
    #1;
    sample();
    expv[0] = model_eval(0, rs, rt, wr, mr, br, rq, rdy);
    expv[1] = model_eval(1, rs, rt, wr, mr, br, rq, rdy);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clock);
    #1;
    sample();
    for (int k = 0; k < 2; k++) begin
      total_cnt++;
      if (obs[k] !== 8'b00110000) $display("FAIL reset dut%0d: got %b expected %b", k, obs[k], 8'b00110000);
      else pass_cnt++;
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_load_use();
    logic [4:0] rs [4] = '{5, 5, 1, 0};
    logic [4:0] rt [4] = '{3, 3, 7, 0};
    logic [4:0] wr [4] = '{5, 5, 7, 0};
    logic       mr [4] = '{1, 0, 1, 0};
    logic [7:0] e  [4] = '{8'b00010000, 8'b11000000, 8'b00010000, 8'b11000000};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      step(rs[c], rt[c], wr[c], mr[c], 0, 0, 0);
      for (int k = 0; k < 2; k++) begin
        total_cnt++;
        if (obs[k] !== e[c]) $display("FAIL load_use c%0d dut%0d: got %b expected %b", c, k, obs[k], e[c]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_zero_reg();
    logic [4:0] rt [2] = '{0, 4};
    do_reset();
    for (int c = 0; c < 2; c++) begin
      step(0, rt[c], 0, 1, 0, 0, 0);
      for (int k = 0; k < 2; k++) begin
        total_cnt++;
        if (obs[k] !== 8'b11000000) $display("FAIL zero_reg c%0d dut%0d: got %b expected %b", c, k, obs[k], 8'b11000000);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_mem_wait();
    logic       rq  [6] = '{1, 1, 1, 1, 1, 0};
    logic       rdy [6] = '{0, 0, 0, 0, 1, 0};
    logic [7:0] e0  [6] = '{8'b00001000, 8'b00001001, 8'b00001001, 8'b00001001,
                            8'b11000001, 8'b11000000};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      step(0, 0, 0, 0, 0, rq[c], rdy[c]);
      total_cnt++;
      if (obs[0] !== e0[c]) $display("FAIL mem_wait c%0d dut0: got %b expected %b", c, obs[0], e0[c]);
      else pass_cnt++;
      total_cnt++;
      if (obs[1] !== expv[1]) $display("FAIL mem_wait_model c%0d dut1: got %b expected %b", c, obs[1], expv[1]);
      else pass_cnt++;
    end
  endtask

  task automatic test_flush();
    logic       br  [9] = '{1, 0, 0, 1, 0, 0, 0, 0, 0};
    logic       rq  [9] = '{0, 0, 0, 0, 1, 1, 1, 0, 0};
    logic       rdy [9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
    logic       mr  [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    logic [7:0] e0  [9] = '{8'b11110000, 8'b11000000, 8'b11000000, 8'b11110000, 8'b00001000,
                            8'b00001001, 8'b11000001, 8'b00010000, 8'b11000000};
    logic [7:0] e1  [9] = '{8'b11110000, 8'b11110010, 8'b11000000, 8'b11110000, 8'b00001010,
                            8'b00001001, 8'b11000001, 8'b11110010, 8'b11000000};
    do_reset();
    for (int c = 0; c < 9; c++) begin
      step(5, 0, 5, mr[c], br[c], rq[c], rdy[c]);
      total_cnt++;
      if (obs[0] !== e0[c]) $display("FAIL flush c%0d dut0: got %b expected %b", c, obs[0], e0[c]);
      else pass_cnt++;
      total_cnt++;
      if (obs[1] !== e1[c]) $display("FAIL flush c%0d dut1: got %b expected %b", c, obs[1], e1[c]);
      else pass_cnt++;
    end
  endtask

  task automatic test_timeout();
    logic       rq [7] = '{1, 1, 1, 1, 1, 0, 0};
    logic [7:0] e0 [7] = '{8'b00001000, 8'b00001001, 8'b00001001, 8'b00001001,
                           8'b00001001, 8'b11000001, 8'b11000000};
    logic [7:0] e1 [7] = '{8'b00001000, 8'b00001001, 8'b00001001, 8'b11000001,
                           8'b00001100, 8'b11000101, 8'b11000100};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      step(0, 0, 0, 0, 0, rq[c], 0);
      total_cnt++;
      if (obs[0] !== e0[c]) $display("FAIL timeout c%0d dut0: got %b expected %b", c, obs[0], e0[c]);
      else pass_cnt++;
      total_cnt++;
      if (obs[1] !== e1[c]) $display("FAIL timeout c%0d dut1: got %b expected %b", c, obs[1], e1[c]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    total_cnt++;
    if (obs[0] !== 8'b00001001) $display("FAIL mid_wait_pre dut0: got %b expected %b", obs[0], 8'b00001001);
    else pass_cnt++;
    #2;
    reset_n = 1'b0;
    #1;
    sample();
    for (int k = 0; k < 2; k++) begin
      total_cnt++;
      if (obs[k] !== 8'b00110000) $display("FAIL mid_wait_reset dut%0d: got %b expected %b", k, obs[k], 8'b00110000);
      else pass_cnt++;
    end
`ifdef HAZARD_PERF_CNT_EN
    total_cnt++;
    if ({stall_cnt0, flush_cnt0, stall_cnt1, flush_cnt1} !== 128'd0)
      $display("FAIL perf_cnt_reset: got %0d %0d %0d %0d expected 0", stall_cnt0, flush_cnt0, stall_cnt1, flush_cnt1);
    else pass_cnt++;
`endif
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    reset_n = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      total_cnt++;
      if (obs[k] !== 8'b11000000) $display("FAIL mid_wait_after dut%0d: got %b expected %b", k, obs[k], 8'b11000000);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [7:0] e;
    do_reset();
    repeat (400) begin
      logic rq_r;
      rq_r = ($urandom_range(0, 2) == 0);
      step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0),
           rq_r, rq_r && ($urandom_range(0, 1) == 1));
      exp_q.push_back(expv[0]);
      exp_q.push_back(expv[1]);
      for (int k = 0; k < 2; k++) begin
        e = exp_q.pop_front();
        total_cnt++;
        if (obs[k] !== e) $display("FAIL random dut%0d: got %b expected %b", k, obs[k], e);
        else pass_cnt++;
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    test_reset();
    test_load_use();
    test_zero_reg();
    test_flush();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
